// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths, screen limits and scheduler state encoding
package vga_pkg;
   localparam int SCR_W = 320;
   localparam int SCR_H = 240;
   localparam int X_W   = $clog2(SCR_W);
   localparam int Y_W   = $clog2(SCR_H);
   localparam int C_W   = 3;
   localparam int WD_W  = 12;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ERASE = 2'd1,
      ST_DRAW  = 2'd2
   } sched_state_t;
endpackage

// File: rtl/sched_next_en.sv
// rtl/sched_next_en.sv - next enabled client index above (or at, when i_incl) i_cur
module sched_next_en #(
   parameter int NCLI = 3,
   parameter int IW   = (NCLI > 1) ? $clog2(NCLI) : 1
) (
   input  logic [NCLI-1:0] i_en,
   input  logic [IW-1:0]   i_cur,
   input  logic            i_incl,
   output logic [IW-1:0]   o_nxt,
   output logic            o_valid
);
   // Scan downward so the lowest qualifying index is the last one written.
   always_comb begin
      o_nxt   = '0;
      o_valid = 1'b0;
      for (int i = NCLI - 1; i >= 0; i--) begin
         if (i_en[i] && ((i_incl && (i >= int'(i_cur))) || (i > int'(i_cur)))) begin
            o_nxt   = IW'(i);
            o_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/vga_draw_sched.sv
// rtl/vga_draw_sched.sv - frame scheduler: erase all enabled sprites, then draw them
module vga_draw_sched
   import vga_pkg::*;
#(
   parameter int NCLI = 3,
   parameter int TMO  = 4095
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  frame_tick,
   input  logic [NCLI-1:0]       cli_en,
   input  logic [NCLI*X_W-1:0]   cli_x,
   input  logic [NCLI*Y_W-1:0]   cli_y,
   input  logic [NCLI*C_W-1:0]   cli_colour,
   input  logic [NCLI-1:0]       cli_finish,
   output logic [NCLI-1:0]       erase_signal,
   output logic [NCLI-1:0]       draw_signal,
   output logic [X_W-1:0]        x_out,
   output logic [Y_W-1:0]        y_out,
   output logic [C_W-1:0]        colour,
   output logic                  plot,
   output logic                  busy,
   output logic                  overrun_err,
   output logic                  timeout_err
);
   localparam int IW = (NCLI > 1) ? $clog2(NCLI) : 1;

   sched_state_t    r_state, w_state_nxt;
   logic [IW-1:0]   r_cur, w_cur_nxt;
   logic            r_pending;
   logic [WD_W-1:0] r_wd;
   logic            r_overrun, r_timeout, r_plot;
   logic [X_W-1:0]  r_x;
   logic [Y_W-1:0]  r_y;
   logic [C_W-1:0]  r_col;

   logic [IW-1:0]   w_nxt, w_low;
   logic            w_nxt_vld, w_low_vld;
   logic            w_active, w_tmo, w_adv, w_pend_clr;

   sched_next_en #(.NCLI(NCLI), .IW(IW)) u_next (
      .i_en(cli_en), .i_cur(r_cur), .i_incl(1'b0), .o_nxt(w_nxt), .o_valid(w_nxt_vld)
   );

   sched_next_en #(.NCLI(NCLI), .IW(IW)) u_low (
      .i_en(cli_en), .i_cur('0), .i_incl(1'b1), .o_nxt(w_low), .o_valid(w_low_vld)
   );

   assign w_active = (r_state != ST_IDLE);
   assign w_tmo    = w_active && (r_wd == WD_W'(TMO));
   assign w_adv    = w_active && (cli_finish[r_cur] || w_tmo);

   always_comb begin
      w_state_nxt = r_state;
      w_cur_nxt   = r_cur;
      w_pend_clr  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (frame_tick || r_pending) begin
               w_pend_clr = 1'b1;
               if (w_low_vld) begin
                  w_state_nxt = ST_ERASE;
                  w_cur_nxt   = w_low;
               end
            end
         end
         ST_ERASE: begin
            if (w_adv) begin
               if (w_nxt_vld) begin
                  w_cur_nxt = w_nxt;
               end else if (w_low_vld) begin
                  w_state_nxt = ST_DRAW;
                  w_cur_nxt   = w_low;
               end else begin
                  // Every client was disabled mid-frame: nothing left to draw.
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_DRAW: begin
            if (w_adv) begin
               if (w_nxt_vld) w_cur_nxt = w_nxt;
               else           w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_cur     <= '0;
         r_pending <= 1'b0;
         r_wd      <= '0;
         r_overrun <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cur   <= w_cur_nxt;
         if (!w_active || (w_state_nxt != r_state) || (w_cur_nxt != r_cur)) r_wd <= '0;
         else                                                               r_wd <= r_wd + WD_W'(1);
         // A tick during a frame queues one more frame; a second queued tick is lost.
         if (w_active && frame_tick) begin
            r_pending <= 1'b1;
            if (r_pending) r_overrun <= 1'b1;
         end else if (w_pend_clr) begin
            r_pending <= 1'b0;
         end
         if (w_tmo) r_timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_x    <= '0;
         r_y    <= '0;
         r_col  <= '0;
         r_plot <= 1'b0;
      end else begin
         r_x    <= cli_x[r_cur*X_W +: X_W];
         r_y    <= cli_y[r_cur*Y_W +: Y_W];
         r_col  <= cli_colour[r_cur*C_W +: C_W];
         r_plot <= w_active;
      end
   end

   always_comb begin
      erase_signal = '0;
      draw_signal  = '0;
      if (r_state == ST_ERASE) erase_signal[r_cur] = 1'b1;
      if (r_state == ST_DRAW)  draw_signal[r_cur]  = 1'b1;
   end

   assign x_out       = r_x;
   assign y_out       = r_y;
   assign colour      = r_col;
   assign plot        = r_plot;
   assign busy        = w_active;
   assign overrun_err = r_overrun;
   assign timeout_err = r_timeout;
endmodule
